// File: rtl/bcd_seq_pkg.sv
// Shared definitions for the BCD count sequencer.
//   - Command opcodes carried on cmd_op.
//   - Controller state encoding.
//   - wrap_step: one wrap-around step of a digit in the range 0..limit.
package bcd_seq_pkg;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_RUN_UP   = 2'b01;
  localparam logic [1:0] OP_RUN_DOWN = 2'b10;
  localparam logic [1:0] OP_RSVD     = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counting up past limit returns to 0; counting down past 0 returns to limit.
  function automatic int unsigned wrap_step(input int unsigned val,
                                            input logic        up,
                                            input int unsigned limit);
    if (up) return (val >= limit) ? 32'd0 : val + 32'd1;
    else    return (val == 32'd0) ? limit : val - 32'd1;
  endfunction

endpackage

// File: rtl/bcd_step_counter.sv
// Wrap-around up/down digit register.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : replace count with load_val (has priority over en)
//   load_val  : value to load
//   en        : step count by one in the direction given by up
//   up        : 1 = increment (LIMIT -> 0), 0 = decrement (0 -> LIMIT)
//   count     : current digit
module bcd_step_counter
  import bcd_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int LIMIT = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic [N-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= N'(wrap_step(32'(count), up, LIMIT));
  end

endmodule

// File: rtl/bcd_count_sequencer.sv
// Controller sequencing a single BCD digit toward a commanded target.
//   clk, rst             : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only while idle)
//   cmd_op, cmd_data     : opcode (LOAD / RUN_UP / RUN_DOWN / reserved) and operand
//   stop                 : abort a run; wins over hold and a coincident tick
//   hold                 : freeze the step prescaler while running
//   count                : current digit
//   busy                 : run in progress
//   dir                  : direction of the last accepted run (1 = up)
//   done                 : one-cycle pulse on arrival (or equal-target run)
//   err                  : one-cycle pulse when an operand exceeds LIMIT
module bcd_count_sequencer
  import bcd_seq_pkg::*;
#(
  parameter int N        = 4,
  parameter int LIMIT    = 9,
  parameter int PRESCALE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [N-1:0] cmd_data,
  input  logic         stop,
  input  logic         hold,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         dir,
  output logic         done,
  output logic         err
);

  localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [N-1:0]   LIMIT_V    = N'(LIMIT);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [N-1:0]  target_q;
  logic          dir_q, done_q, err_q;

  logic          accept, is_run_op, data_ok, run_ok;
  logic          run_start, run_equal, running, tick, arrive;
  logic          load_en;
  logic [N-1:0]  step_val;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign dir       = dir_q;
  assign done      = done_q;
  assign err       = err_q;

  // Command decode
  assign accept    = cmd_valid && cmd_ready;
  assign is_run_op = (cmd_op == OP_RUN_UP) || (cmd_op == OP_RUN_DOWN);
  assign data_ok   = (cmd_data <= LIMIT_V);
  assign run_ok    = accept && is_run_op && data_ok;
  assign run_start = run_ok && (cmd_data != count);
  assign run_equal = run_ok && (cmd_data == count);
  assign load_en   = accept && (cmd_op == OP_LOAD) && data_ok;

  // Stepping: a tick is suppressed by hold (prescaler frozen) and by stop.
  assign running  = (state_q == ST_RUN);
  assign tick     = running && !stop && !hold && (presc_q == PRESC_LAST);
  assign step_val = N'(wrap_step(32'(count), dir_q, LIMIT));
  assign arrive   = tick && (step_val == target_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (run_start)       state_d = ST_RUN;
      ST_RUN:  if (stop || arrive)  state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst)                           presc_q <= '0;
    else if (run_start)                presc_q <= '0;
    else if (running && !hold && !stop) presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  // Target is only consulted while running, so it needs no reset.
  always_ff @(posedge clk) begin
    if (run_start) target_q <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (rst)         dir_q <= 1'b0;
    else if (run_ok) dir_q <= (cmd_op == OP_RUN_UP);
  end

  // Registered status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= arrive || run_equal;
      err_q  <= accept && !data_ok && (is_run_op || (cmd_op == OP_LOAD));
    end
  end

  bcd_step_counter #(
    .N     (N),
    .LIMIT (LIMIT)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en),
    .load_val (cmd_data),
    .en       (tick),
    .up       (dir_q),
    .count    (count)
  );

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Directed bench for bcd_count_sequencer (N=4, LIMIT=9, PRESCALE=2).
module tb_bcd_count_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_data = 4'd0;
  logic       stop = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] count;
  logic       busy, dir, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_count_sequencer #(.N(4), .LIMIT(9), .PRESCALE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .stop      (stop),
    .hold      (hold),
    .count     (count),
    .busy      (busy),
    .dir       (dir),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dir", dir, 0);

    // 2: LOAD 3, RUN_UP 7 -> 4,5,6,7 every 2 cycles, ends 8 cycles after accept
    send(2'b00, 4'd3);
    chk("load3_count", count, 3);
    chk("load3_err", err, 0);
    send(2'b01, 4'd7);
    chk("up_start_busy", busy, 1);
    chk("up_start_ready", cmd_ready, 0);
    chk("up_start_dir", dir, 1);
    chk("up_start_count", count, 3);
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("up_count", count, 3 + e / 2);
      chk("up_busy", busy, (e < 8) ? 1 : 0);
      chk("up_done", done, (e == 8) ? 1 : 0);
    end
    step();
    chk("up_done_gone", done, 0);
    chk("up_ready_back", cmd_ready, 1);
    chk("up_count_hold", count, 7);

    // 3: LOAD 2, RUN_DOWN 8 -> 1,0,9,8
    send(2'b00, 4'd2);
    send(2'b10, 4'd8);
    chk("down_dir", dir, 0);
    for (int e = 1; e <= 8; e++) begin
      int unsigned exp_cnt;
      case (e)
        1: exp_cnt = 2;  2, 3: exp_cnt = 1;  4, 5: exp_cnt = 0;
        6, 7: exp_cnt = 9;  default: exp_cnt = 8;
      endcase
      step();
      chk("down_count", count, exp_cnt);
      chk("down_done", done, (e == 8) ? 1 : 0);
      chk("down_busy", busy, (e < 8) ? 1 : 0);
    end
    step();
    chk("down_done_gone", done, 0);

    // 4: errors, equal target, reserved opcode (count is 8)
    send(2'b00, 4'd12);
    chk("load12_err", err, 1);
    chk("load12_count", count, 8);
    step();
    chk("load12_err_gone", err, 0);
    send(2'b01, 4'd8);
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 0);
    chk("eq_count", count, 8);
    chk("eq_dir", dir, 1);
    step();
    chk("eq_done_gone", done, 0);
    send(2'b01, 4'd10);
    chk("up10_err", err, 1);
    chk("up10_busy", busy, 0);
    send(2'b10, 4'd8);
    chk("eq_down_dir", dir, 0);
    chk("eq_down_done", done, 1);
    send(2'b11, 4'd5);
    chk("rsvd_err", err, 0);
    chk("rsvd_count", count, 8);
    chk("rsvd_busy", busy, 0);
    chk("rsvd_done", done, 0);

    // 5a: RUN_UP 9 from 0 with 5 hold cycles -> arrival at edge 23 instead of 18
    send(2'b00, 4'd0);
    send(2'b01, 4'd9);
    for (int e = 1; e <= 23; e++) begin
      hold = (e >= 4 && e <= 8);
      step();
      if (e == 8) chk("hold_frozen", count, 1);
      if (e == 9) chk("hold_resume", count, 2);
      if (e == 18) chk("hold_not_early", done, 0);
      if (e == 22) begin
        chk("hold_pre_count", count, 8);
        chk("hold_pre_busy", busy, 1);
      end
      if (e == 23) begin
        chk("hold_arr_count", count, 9);
        chk("hold_arr_busy", busy, 0);
        chk("hold_arr_done", done, 1);
      end
    end
    hold = 1'b0;
    step();

    // 5b: stop on a tick edge
    send(2'b00, 4'd0);
    send(2'b01, 4'd9);
    for (int e = 1; e <= 6; e++) begin
      stop = (e == 6);
      step();
    end
    stop = 1'b0;
    chk("stop_count", count, 2);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_ready", cmd_ready, 1);
    step();
    chk("stop_done_after", done, 0);
    chk("stop_count_after", count, 2);

    // 6: reset mid-run coincident with a tick, then LOAD 5
    send(2'b00, 4'd0);
    send(2'b10, 4'd7);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_count", count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_dir", dir, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_ready", cmd_ready, 1);
    send(2'b00, 4'd5);
    chk("mrst_load5", count, 5);

    // back-to-back: a new run accepted right after done
    send(2'b01, 4'd6);
    step();
    step();
    chk("b2b_done", done, 1);
    chk("b2b_count", count, 6);
    send(2'b10, 4'd5);
    chk("b2b_busy", busy, 1);
    chk("b2b_dir", dir, 0);
    step();
    step();
    chk("b2b_done2", done, 1);
    chk("b2b_count2", count, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
